// File: rtl/apb_ethernet_tx_buffer_x32.sv
// APB-fed Ethernet transmit frame buffer: firmware stages 32-bit words,
// commits whole frames, and a small FSM streams them onto the MAC bus.
module apb_ethernet_tx_buffer_x32 #(
    parameter int DEPTH     = 1024,
    parameter int HDR_DEPTH = 32
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        eth_link_up,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic        tx_data_valid,
    output logic [2:0]  tx_bytes_valid,
    output logic [31:0] tx_data,
    output logic        tx_frame_pending
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int HW  = $clog2(HDR_DEPTH);
    localparam int HPW = HW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA} state_t;

    logic [31:0] mem [DEPTH];
    logic [10:0] hdr_mem [HDR_DEPTH];

    // wr_ptr runs ahead of cm_ptr by the uncommitted words
    logic [PW-1:0]  wr_ptr, cm_ptr, rd_ptr;
    logic [HPW-1:0] hdr_wr, hdr_rd;
    logic           bad;
    logic           commit_pend;
    logic [10:0]    commit_len;
    logic [10:0]    rem;
    state_t         state;

    logic [PW-1:0]  used, uncommitted;
    logic [HPW-1:0] hdr_cnt;
    logic [12:0]    free_words;
    logic [11:0]    need_words;
    logic [10:0]    len;
    logic           data_full, hdr_full, len_ok, commit_ok;
    logic           access, load;
    logic           is_word, is_commit, is_stat, is_abort;
    logic           acc_err, do_push, do_commit, do_reject;
    logic           do_abort, set_bad;
    logic [31:0]    stat;

    assign access      = psel && penable && !pready;
    assign used        = wr_ptr - rd_ptr;
    assign uncommitted = wr_ptr - cm_ptr;
    assign hdr_cnt     = hdr_wr - hdr_rd;
    assign data_full   = (used == PW'(DEPTH));
    assign hdr_full    = (hdr_cnt == HPW'(HDR_DEPTH));
    assign free_words  = 13'(DEPTH) - 13'(used);
    assign len         = pwdata[10:0];
    assign need_words  = (12'(len) + 12'd3) >> 2;
    assign len_ok      = (len >= 11'd14) && (len <= 11'd1514);
    assign commit_ok   = len_ok && !bad && !hdr_full &&
                         (13'(need_words) == 13'(uncommitted));
    assign stat        = {5'b0, 11'(hdr_cnt), 3'b0, free_words};
    assign is_word     = (paddr == 12'h000);
    assign is_commit   = (paddr == 12'h004);
    assign is_stat     = (paddr == 12'h008);
    assign is_abort    = (paddr == 12'h00C);
    assign load        = (state == START) ||
                         ((state == DATA) && (rem != 11'd0));
    assign tx_frame_pending = (hdr_cnt != '0);

    always_comb begin
        acc_err   = 1'b1;
        do_push   = 1'b0;
        do_commit = 1'b0;
        do_reject = 1'b0;
        do_abort  = 1'b0;
        set_bad   = 1'b0;
        unique case (1'b1)
            is_word: begin
                acc_err = !pwrite || data_full;
                do_push = pwrite && !data_full;
                set_bad = pwrite && data_full;
            end
            is_commit: begin
                acc_err   = !pwrite || !commit_ok;
                do_commit = pwrite && commit_ok;
                do_reject = pwrite && !commit_ok;
            end
            is_stat: acc_err = pwrite;
            is_abort: begin
                acc_err  = !pwrite;
                do_abort = pwrite;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (access && do_push && eth_link_up)
            mem[wr_ptr[AW-1:0]] <= {pwdata[7:0], pwdata[15:8],
                                    pwdata[23:16], pwdata[31:24]};
        if (commit_pend && eth_link_up)
            hdr_mem[hdr_wr[HW-1:0]] <= commit_len;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            prdata         <= '0;
            pready         <= 1'b0;
            pslverr        <= 1'b0;
            wr_ptr         <= '0;
            cm_ptr         <= '0;
            rd_ptr         <= '0;
            hdr_wr         <= '0;
            hdr_rd         <= '0;
            bad            <= 1'b0;
            commit_pend    <= 1'b0;
            commit_len     <= '0;
            rem            <= '0;
            state          <= IDLE;
            tx_start       <= 1'b0;
            tx_data_valid  <= 1'b0;
            tx_bytes_valid <= '0;
            tx_data        <= '0;
        end else begin
            pready  <= access;
            pslverr <= access && acc_err;
            prdata  <= (access && is_stat && !pwrite) ? stat : 32'd0;
            if (!eth_link_up) begin
                wr_ptr         <= '0;
                cm_ptr         <= '0;
                rd_ptr         <= '0;
                hdr_wr         <= '0;
                hdr_rd         <= '0;
                bad            <= 1'b0;
                commit_pend    <= 1'b0;
                rem            <= '0;
                state          <= IDLE;
                tx_start       <= 1'b0;
                tx_data_valid  <= 1'b0;
                tx_bytes_valid <= '0;
                tx_data        <= '0;
            end else begin
                if (access) begin
                    if (do_push) wr_ptr <= wr_ptr + 1'b1;
                    if (set_bad) bad <= 1'b1;
                    if (do_reject || do_abort) begin
                        wr_ptr <= cm_ptr;
                        bad    <= 1'b0;
                    end
                    if (do_commit) begin
                        commit_pend <= 1'b1;
                        commit_len  <= len;
                    end
                end
                // publish the frame one cycle after the pready cycle
                if (commit_pend) begin
                    cm_ptr      <= wr_ptr;
                    hdr_wr      <= hdr_wr + 1'b1;
                    commit_pend <= 1'b0;
                end
                case (state)
                    IDLE: begin
                        if (tx_frame_pending && tx_ready) begin
                            state    <= START;
                            tx_start <= 1'b1;
                            rem      <= hdr_mem[hdr_rd[HW-1:0]];
                            hdr_rd   <= hdr_rd + 1'b1;
                        end
                    end
                    START: begin
                        tx_start <= 1'b0;
                        state    <= DATA;
                    end
                    DATA: begin
                        if (rem == 11'd0) begin
                            state          <= IDLE;
                            tx_data_valid  <= 1'b0;
                            tx_bytes_valid <= '0;
                            tx_data        <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (load) begin
                    tx_data       <= mem[rd_ptr[AW-1:0]];
                    rd_ptr        <= rd_ptr + 1'b1;
                    tx_data_valid <= 1'b1;
                    if (rem > 11'd4) begin
                        tx_bytes_valid <= 3'd4;
                        rem            <= rem - 11'd4;
                    end else begin
                        tx_bytes_valid <= rem[2:0];
                        rem            <= '0;
                    end
                end
            end
        end
    end

endmodule
